wb_merge: RTL and testbench
===========================

// Module: wb_merge
// PURPOSE
//  Writeback merge stage directly upstream of the 32x32 register file write port.
//  Merges single-cycle ALU results with variable-latency load results into one registered write.
//  Buffers load results in a small FIFO and keeps a pending-load scoreboard that decode uses for stalls.
// PARAMETERS
//  LD_FIFO_DEPTH  4   load-result FIFO entries; power of 2, >=2
//  XLEN           32  data width
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous reset, active-low
//  alu_valid      in   1      ALU result valid this cycle; no ready, always accepted
//  alu_rd         in   5      ALU destination register
//  alu_data       in   XLEN   ALU result
//  ld_valid       in   1      load result valid
//  ld_ready       out  1      = !fifo_full (combinational)
//  ld_rd          in   5      load destination register
//  ld_data        in   XLEN   load result
//  sb_set         in   1      decode issued a load this cycle
//  sb_rd          in   5      destination register of the issued load
//  pending        out  32     scoreboard; bit i=1 -> load to xi outstanding; bit0 always 0
//  we             out  1      register file write enable (registered)
//  rd_addr        out  5      register file write address (registered)
//  rd_data        out  XLEN   register file write data (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): we=0, rd_addr=0, rd_data=0, pending=0, FIFO empty; ld_ready=1 next cycle.
//  Load push: ld_valid && ld_ready at edge N -> entry is written to the FIFO tail.
//  Arbitration each cycle: ALU has strict priority; FIFO head is popped only when !alu_valid && !empty.
//  Output register: at the edge, the selected source loads we/rd_addr/rd_data.
//  -> ALU latency 1: valid in cycle N gives we=1 in cycle N+1.
//  -> Load latency min 2: accepted at edge N, head visible in cycle N+1, we=1 in cycle N+2.
//  No source selected: we=0; rd_addr and rd_data hold their previous values.
//  rd==0: the write is consumed normally (FIFO pop, handshake) but we stays 0.
//  FIFO full: ld_ready=0; a simultaneous pop does not raise ld_ready in the same cycle (no full-bypass).
//  FIFO pointers: log2(DEPTH)+1 bits; wrap-around through the extra MSB.
//  Push and pop in the same cycle on a non-empty FIFO: occupancy is unchanged.
//  Scoreboard: bit sb_rd is set at the edge when sb_set && sb_rd!=0.
//  Scoreboard: bit rd is cleared at the edge when a load pop for rd is selected.
//  Scoreboard: same-cycle set and clear of the same bit -> set wins (a new load is outstanding).
//  Scoreboard: ALU writes never touch pending.
//  Reset mid-operation: FIFO contents are discarded, no write is issued, pending=0.
//  Illegal: ld_valid while full; the input is ignored and the assertion fires in simulation.
// CONFIGURATION
//  WB_FWD_EN defined: adds the following ports.
//    rs1_addr, rs2_addr  in   5     read addresses
//    rf_rs1, rf_rs2      in   XLEN  register file read data
//    fwd_rs1, fwd_rs2    out  XLEN  forwarded read data
//  WB_FWD_EN forwarding rule, combinational, per port:
//    fwd_rsX = (we && rd_addr!=0 && rd_addr==rsX_addr) ? rd_data : rf_rsX
//    This covers the write-then-read gap of the register file.
//  WB_FWD_EN not defined: none of these ports exist; no logic is added.
// TESTING
//  1. Reset, then alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle we=1, rd_addr=5, rd_data=0xDEADBEEF.
//  2. sb_set rd=7; later ld_valid rd=7, data=0x1234 with no ALU traffic
//     -> pending[7]=1 until the write; we=1 with rd 7 two cycles after accept; pending[7]=0 same edge.
//  3. Push 4 loads while ALU is continuously valid -> ld_ready=0 after the 4th push.
//     Then drop alu_valid -> 4 load writes in consecutive cycles, in FIFO order; ld_ready=1 again.
//  4. ALU rd=0 data=0xFFFFFFFF, then load rd=0 -> we stays 0 for both; the FIFO still drains.
//  5. sb_set rd=9 in the same cycle as the pop of a load to rd 9 -> pending[9]=1 after the edge.
//  6. rst_n=0 with 3 loads queued and pending=0x0000_0F00 -> next cycle FIFO empty, pending=0, we=0.
//     With WB_FWD_EN: we to x3 with rs1_addr=3 -> fwd_rs1=rd_data, not rf_rs1.

Source files
------------

// File: rtl/wb_merge.sv
// wb_merge: writeback merge stage in front of the register file write port.
// ALU results have strict priority over buffered load results; loads wait in
// a small FIFO. A pending-load scoreboard tells decode which registers still
// have a load in flight.
// Optional feature: define WB_FWD_EN to add write-then-read forwarding ports.
module wb_merge #(
    parameter int LD_FIFO_DEPTH = 4,
    parameter int XLEN          = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            sb_set,
    input  logic [4:0]      sb_rd,
`ifdef WB_FWD_EN
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    output logic [XLEN-1:0] fwd_rs1,
    output logic [XLEN-1:0] fwd_rs2,
`endif
    output logic [31:0]     pending,
    output logic            we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    localparam int AW = $clog2(LD_FIFO_DEPTH);

    logic [4:0]      fifoRd_q   [LD_FIFO_DEPTH];
    logic [XLEN-1:0] fifoData_q [LD_FIFO_DEPTH];
    logic [AW:0]     wrPtr_q, wrPtr_d;
    logic [AW:0]     rdPtr_q, rdPtr_d;
    logic            fifoFull, fifoEmpty;
    logic            push, pop;
    logic [4:0]      headRd;
    logic [XLEN-1:0] headData;

    logic            we_q, we_d;
    logic [4:0]      rdAddr_q, rdAddr_d;
    logic [XLEN-1:0] rdData_q, rdData_d;
    logic [31:0]     pending_q, pending_d;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign ld_ready  = !fifoFull;
    assign push      = ld_valid && !fifoFull;
    assign pop       = !alu_valid && !fifoEmpty;
    assign headRd    = fifoRd_q[rdPtr_q[AW-1:0]];
    assign headData  = fifoData_q[rdPtr_q[AW-1:0]];

    // Advance the FIFO pointers on accepted pushes and selected pops.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push) wrPtr_d = wrPtr_q + {{AW{1'b0}}, 1'b1};
        if (pop)  rdPtr_d = rdPtr_q + {{AW{1'b0}}, 1'b1};
    end

    // FIFO storage needs no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoRd_q[wrPtr_q[AW-1:0]]   <= ld_rd;
            fifoData_q[wrPtr_q[AW-1:0]] <= ld_data;
        end
    end

    // FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Select the write source: ALU first, then the FIFO head; x0 writes are suppressed.
    always_comb begin
        we_d     = 1'b0;
        rdAddr_d = rdAddr_q;
        rdData_d = rdData_q;
        if (alu_valid) begin
            we_d     = (alu_rd != 5'd0);
            rdAddr_d = alu_rd;
            rdData_d = alu_data;
        end else if (pop) begin
            we_d     = (headRd != 5'd0);
            rdAddr_d = headRd;
            rdData_d = headData;
        end
    end

    // Registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            rdAddr_q <= '0;
            rdData_q <= '0;
        end else begin
            we_q     <= we_d;
            rdAddr_q <= rdAddr_d;
            rdData_q <= rdData_d;
        end
    end

    // Scoreboard update: clear on load pop, then set on issue so a new load wins.
    always_comb begin
        pending_d = pending_q;
        if (pop)                      pending_d[headRd] = 1'b0;
        if (sb_set && sb_rd != 5'd0)  pending_d[sb_rd]  = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign we      = we_q;
    assign rd_addr = rdAddr_q;
    assign rd_data = rdData_q;
    assign pending = pending_q;

`ifdef WB_FWD_EN
    assign fwd_rs1 = (we_q && rdAddr_q != 5'd0 && rdAddr_q == rs1_addr) ? rdData_q : rf_rs1;
    assign fwd_rs2 = (we_q && rdAddr_q != 5'd0 && rdAddr_q == rs2_addr) ? rdData_q : rf_rs2;
`endif

    // A load offered while the FIFO is full is dropped; flag it in simulation.
    ldOverflow: assert property (@(posedge clk) disable iff (!rst_n) !(ld_valid && fifoFull));

endmodule

// File: tb/tb_wb_merge.sv
// tb_wb_merge: directed scenarios plus randomized traffic for wb_merge,
// compared every cycle against a queue-based model of the merge stage.
module tb_wb_merge;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            aluValid;
    logic [4:0]      aluRd;
    logic [XLEN-1:0] aluData;
    logic            ldValid;
    logic            ldReady;
    logic [4:0]      ldRd;
    logic [XLEN-1:0] ldData;
    logic            sbSet;
    logic [4:0]      sbRd;
    logic [31:0]     pending;
    logic            we;
    logic [4:0]      rdAddr;
    logic [XLEN-1:0] rdData;
`ifdef WB_FWD_EN
    logic [4:0]      rs1Addr, rs2Addr;
    logic [XLEN-1:0] rfRs1, rfRs2, fwdRs1, fwdRs2;
`endif

    wb_merge #(.LD_FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(aluValid), .alu_rd(aluRd), .alu_data(aluData),
        .ld_valid(ldValid), .ld_ready(ldReady), .ld_rd(ldRd), .ld_data(ldData),
        .sb_set(sbSet), .sb_rd(sbRd),
`ifdef WB_FWD_EN
        .rs1_addr(rs1Addr), .rs2_addr(rs2Addr), .rf_rs1(rfRs1), .rf_rs2(rfRs2),
        .fwd_rs1(fwdRs1), .fwd_rs2(fwdRs2),
`endif
        .pending(pending), .we(we), .rd_addr(rdAddr), .rd_data(rdData)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      modelQ[$];
    logic [31:0] modelPend = '0;
    logic        modelWe   = 1'b0;
    logic [4:0]  modelAddr = '0;
    logic [31:0] modelData = '0;
    bit          modelValid = 1'b0;

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour of one clock edge, evaluated from the inputs seen at that edge.
    function automatic void modelStep();
        entry_t head;
        bit     wasFull;
        if (!rst_n) begin
            modelQ.delete();
            modelPend  = '0;
            modelWe    = 1'b0;
            modelAddr  = '0;
            modelData  = '0;
            modelValid = 1'b1;
            return;
        end
        wasFull = (modelQ.size() >= DEPTH);
        if (aluValid) begin
            modelWe   = (aluRd != 0);
            modelAddr = aluRd;
            modelData = aluData;
        end else if (modelQ.size() > 0) begin
            head      = modelQ.pop_front();
            modelWe   = (head.rd != 0);
            modelAddr = head.rd;
            modelData = head.data;
            modelPend[head.rd] = 1'b0;
        end else begin
            modelWe = 1'b0;
        end
        if (ldValid && !wasFull) modelQ.push_back('{rd: ldRd, data: ldData});
        if (sbSet && sbRd != 0) modelPend[sbRd] = 1'b1;
    endfunction

    // Compare all outputs against the model once per cycle.
    task automatic checkOutput();
        checkValue("we",       32'(we),      32'(modelWe));
        checkValue("rd_addr",  32'(rdAddr),  32'(modelAddr));
        checkValue("rd_data",  rdData,       modelData);
        checkValue("pending",  pending,      modelPend);
        checkValue("ld_ready", 32'(ldReady), 32'(modelQ.size() < DEPTH));
    endtask

    always @(negedge clk) begin
        if (modelValid) checkOutput();
    end

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                 input logic ss, input logic [4:0] srd);
        aluValid = av;  aluRd = ard;  aluData = adata;
        ldValid  = lv;  ldRd  = lrd;  ldData  = ldat;
        sbSet    = ss;  sbRd  = srd;
        @(posedge clk);
        modelStep();
        #2;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0;
`ifdef WB_FWD_EN
        rs1Addr = '0; rs2Addr = '0; rfRs1 = '0; rfRs2 = '0;
`endif
        idle();
        idle();
        rst_n = 1'b1;
        checkValue("reset_we",      32'(we),      32'd0);
        checkValue("reset_rd_addr", 32'(rdAddr),  32'd0);
        checkValue("reset_rd_data", rdData,       32'd0);
        checkValue("reset_pending", pending,      32'd0);
        checkValue("reset_ld_ready", 32'(ldReady), 32'd1);

        // ALU write, latency one.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkValue("t1_we",      32'(we),     32'd1);
        checkValue("t1_rd_addr", 32'(rdAddr), 32'd5);
        checkValue("t1_rd_data", rdData,      32'hDEADBEEF);
`ifdef WB_FWD_EN
        rs1Addr = 5'd5; rs2Addr = 5'd6; rfRs1 = 32'h1111_1111; rfRs2 = 32'h2222_2222;
        #1;
        checkValue("fwd_rs1_hit",  fwdRs1, 32'hDEADBEEF);
        checkValue("fwd_rs2_miss", fwdRs2, 32'h2222_2222);
        rs1Addr = '0; rs2Addr = '0;
`endif

        // Scoreboard set, then the load completes two cycles after accept.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        checkValue("t2_pending_set", pending, 32'h0000_0080);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        checkValue("t2_we_accept", 32'(we), 32'd0);
        checkValue("t2_pending_hold", pending, 32'h0000_0080);
        idle();
        checkValue("t2_we",      32'(we),     32'd1);
        checkValue("t2_rd_addr", 32'(rdAddr), 32'd7);
        checkValue("t2_rd_data", rdData,      32'h1234);
        checkValue("t2_pending_clr", pending, 32'd0);

        // Fill the FIFO behind continuous ALU traffic, then drain in order.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'(32'h100 + i), 1'b0, 5'd0);
        checkValue("t3_ld_ready_full", 32'(ldReady), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            checkValue("t3_drain_we",   32'(we),     32'd1);
            checkValue("t3_drain_addr", 32'(rdAddr), 32'(10 + i));
            checkValue("t3_drain_data", rdData,      32'(32'h100 + i));
        end
        checkValue("t3_ld_ready_again", 32'(ldReady), 32'd1);

        // Writes to x0 are consumed but never enable the write port.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkValue("t4_alu_x0_we", 32'(we), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
        idle();
        checkValue("t4_ld_x0_we",   32'(we), 32'd0);
        checkValue("t4_ld_x0_data", rdData,  32'h55);
        checkValue("t4_ld_ready",   32'(ldReady), 32'd1);

        // Issue and pop of the same register in one cycle: set wins.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        checkValue("t5_pending", pending,     32'h0000_0200);
        checkValue("t5_rd_addr", 32'(rdAddr), 32'd9);

        // Reset with loads queued and registers pending.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 5'd2, 32'(32'hA0 + i), 1'(i < 3), 5'(20 + i), 32'(i), 1'b1, 5'(8 + i));
        checkValue("t6_pending_pre", pending, 32'h0000_0F00);
        rst_n = 1'b0;
        idle();
        checkValue("t6_we",       32'(we),      32'd0);
        checkValue("t6_pending",  pending,      32'd0);
        checkValue("t6_ld_ready", 32'(ldReady), 32'd1);
        rst_n = 1'b1;
        idle();
        checkValue("t6_empty_we", 32'(we), 32'd0);

        // Randomized traffic; loads are offered only when the model says there is room.
        for (int c = 0; c < 3000; c++) begin
            logic lv;
            rst_n = ($urandom_range(0, 199) != 0);
            lv = (modelQ.size() < DEPTH) && ($urandom_range(0, 9) < 6);
            applyStimulus(1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
                          lv, 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
        end
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
